matrix_seq_driver: RTL and testbench
====================================

MATRIX_SEQ_DRIVER -- requirements
Module: matrix_seq_driver

Interface
REQ-001 Parameter CALC_CYCLES, default 2: cycles `sel` is held with the operation code before any result read.
REQ-002 Parameter RD_LAT, default 1: cycles from `eleSel` change to valid `eleOut`; legal range 1..4.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 opCode  input  6  operation code, sampled with the first accepted input word of a frame.
REQ-006 inData  input  32  matrix element stream; A[0..8] then B[0..8], row-major.
REQ-007 inValid  input  1  upstream word valid.
REQ-008 inReady  output  1  driver accepts `inData` this cycle.
REQ-009 eleSel  output  5  matrix ALU element index: 0-8 = A, 9-17 = B, 18-26 = result C.
REQ-010 eleIn  output  32  element write data to the matrix ALU.
REQ-011 eleWe  output  1  element write strobe, one cycle per element.
REQ-012 sel  output  6  operation select to the matrix ALU; 6'd0 = NOP.
REQ-013 eleOut  input  32  element read data from the matrix ALU.
REQ-014 outData  output  32  result element stream, C[0..8] row-major.
REQ-015 outValid  output  1  `outData` valid.
REQ-016 outReady  input  1  downstream accepts `outData`.
REQ-017 busy  output  1  high from first accepted word to last result handshake.
REQ-018 frameCnt  output  16  completed frames, wraps 16'hFFFF -> 0.

Function
REQ-019 FSM states: IDLE, LOAD, EXEC, RDADDR, RDWAIT, SEND; all outputs registered.
REQ-020 IDLE/LOAD: `inReady`=1; a transfer occurs when `inValid`&&`inReady`.
- On each transfer: next cycle `eleWe`=1, `eleSel`=word index (0..17), `eleIn`=`inData`.
REQ-021 First transfer in IDLE latches `opCode`, sets `busy`, moves to LOAD; index counter increments per transfer, no gaps required.
REQ-022 Transfer of word 17: `inReady` drops the next cycle, FSM enters EXEC after the final write strobe.
REQ-023 EXEC: `sel`=latched opcode for exactly CALC_CYCLES cycles, `eleWe`=0; then `sel` returns to 0, `eleSel`=18, state RDADDR.
REQ-024 RDADDR/RDWAIT: hold `eleSel` for RD_LAT cycles, then capture `eleOut` into `outData`, assert `outValid`, enter SEND.
REQ-025 SEND: `outData`/`outValid` stable until `outValid`&&`outReady`.
- On handshake with `eleSel`<26: `outValid`=0 next cycle, `eleSel`+1, back to RDADDR.
- On handshake with `eleSel`=26: `frameCnt`+1, `busy`=0, `eleSel`=0, IDLE.
REQ-026 Minimum result spacing: RD_LAT+1 cycles between successive `outValid` rises.
REQ-027 `inReady`=0 in EXEC, RDADDR, RDWAIT, SEND; `inValid` there is ignored with no side effect.
REQ-028 `opCode` changes after latch do not affect the frame in progress.
REQ-029 `outReady` held high while `outValid`=0 has no effect.
REQ-030 `eleWe` never asserts with `eleSel`>17; `sel`≠0 only in EXEC.

Reset
REQ-031 While `reset`=1: state IDLE, `inReady`=0, `eleSel`=0, `eleIn`=0, `eleWe`=0, `sel`=0, `outData`=0, `outValid`=0, `busy`=0, `frameCnt`=0.
REQ-032 First rising edge after `reset` falls: `inReady`=1.
REQ-033 Reset mid-frame (any state) discards the partial frame; `outValid` and `eleWe` fall asynchronously, no stale result is emitted afterwards.

Verification
REQ-034 Frame of words 1..18, opCode 6'd1, `outReady`=1 -> `eleWe` pulses eleSel 0..17 with data 1..18, `sel`=1 for 2 cycles, 9 results emitted in order for eleSel 18..26, `frameCnt`=1.
REQ-035 `inValid` toggled every other cycle -> 18 writes with correct indices, no duplicated or skipped index.
REQ-036 `outReady` low for 5 cycles on result 4 -> `outData` stable, `eleSel`=22 held, no lost or repeated result.
REQ-037 `reset` pulsed during result 3 of SEND -> outputs at reset values same cycle; a new full frame afterwards completes with `frameCnt`=1.
REQ-038 `inValid`=1 with data 0xDEAD during EXEC -> no `eleWe`, word not consumed; `frameCnt` preset path to 16'hFFFF + one frame -> 0.
REQ-039 RD_LAT=3, CALC_CYCLES=4 -> `sel` held 4 cycles; each `outData` equals `eleOut` sampled 3 cycles after `eleSel` change.

Source files
------------

// File: rtl/matrix_seq_driver.sv
// Sequencer for a matrix ALU: streams operands A and B in, holds the operation select,
// then reads the nine result elements back out as a ready/valid stream.
module matrix_seq_driver #(
   parameter int unsigned CALC_CYCLES    = 2,
   parameter int unsigned RD_LAT         = 1,
   // Reset value of frameCnt; non-zero only when exercising the wrap path
   parameter logic [15:0] FRAME_CNT_INIT = 16'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opCode,
   input  logic [31:0] inData,
   input  logic        inValid,
   output logic        inReady,
   output logic [4:0]  eleSel,
   output logic [31:0] eleIn,
   output logic        eleWe,
   output logic [5:0]  sel,
   input  logic [31:0] eleOut,
   output logic [31:0] outData,
   output logic        outValid,
   input  logic        outReady,
   output logic        busy,
   output logic [15:0] frameCnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EXEC,
      ST_RDADDR,
      ST_RDWAIT,
      ST_SEND
   } state_t;

   localparam logic [15:0] CALC_LAST = 16'(CALC_CYCLES - 1);
   localparam logic [15:0] RD_LAST   = 16'(RD_LAT - 1);
   localparam logic [4:0]  WORDS     = 5'd18;
   localparam logic [4:0]  C_FIRST   = 5'd18;
   localparam logic [4:0]  C_LAST    = 5'd26;

   state_t      state_q, state_d;
   logic [4:0]  wcnt_q, wcnt_d;
   logic [15:0] cyc_q, cyc_d;
   logic [5:0]  op_q, op_d;
   logic        in_ready_q, in_ready_d;
   logic [4:0]  ele_sel_q, ele_sel_d;
   logic [31:0] ele_in_q, ele_in_d;
   logic        ele_we_q, ele_we_d;
   logic [5:0]  sel_q, sel_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        xfer;

   // in_ready_q is only ever set in IDLE/LOAD, so this is the only accept condition
   assign xfer = inValid && in_ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= 5'd0;
         cyc_q       <= 16'd0;
         op_q        <= 6'd0;
         in_ready_q  <= 1'b0;
         ele_sel_q   <= 5'd0;
         ele_in_q    <= 32'd0;
         ele_we_q    <= 1'b0;
         sel_q       <= 6'd0;
         out_data_q  <= 32'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= FRAME_CNT_INIT;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         cyc_q       <= cyc_d;
         op_q        <= op_d;
         in_ready_q  <= in_ready_d;
         ele_sel_q   <= ele_sel_d;
         ele_in_q    <= ele_in_d;
         ele_we_q    <= ele_we_d;
         sel_q       <= sel_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      cyc_d       = cyc_q;
      op_d        = op_q;
      in_ready_d  = in_ready_q;
      ele_sel_d   = ele_sel_q;
      ele_in_d    = ele_in_q;
      ele_we_d    = 1'b0;
      sel_d       = sel_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      frame_cnt_d = frame_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (xfer) begin
               op_d      = opCode;
               busy_d    = 1'b1;
               ele_we_d  = 1'b1;
               ele_sel_d = 5'd0;
               ele_in_d  = inData;
               wcnt_d    = 5'd1;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // wcnt_q == 18 means the last write strobe is on the bus this cycle
            if (wcnt_q == WORDS) begin
               in_ready_d = 1'b0;
               sel_d      = op_q;
               cyc_d      = 16'd0;
               state_d    = ST_EXEC;
            end else if (xfer) begin
               ele_we_d  = 1'b1;
               ele_sel_d = wcnt_q;
               ele_in_d  = inData;
               wcnt_d    = wcnt_q + 5'd1;
               if (wcnt_q == WORDS - 5'd1) begin
                  in_ready_d = 1'b0;
               end
            end
         end
         ST_EXEC: begin
            if (cyc_q == CALC_LAST) begin
               sel_d     = 6'd0;
               ele_sel_d = C_FIRST;
               cyc_d     = 16'd0;
               state_d   = ST_RDADDR;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         ST_RDADDR: begin
            if (RD_LAST == 16'd0) begin
               out_data_d  = eleOut;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end else begin
               cyc_d   = 16'd1;
               state_d = ST_RDWAIT;
            end
         end
         ST_RDWAIT: begin
            if (cyc_q == RD_LAST) begin
               out_data_d  = eleOut;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         ST_SEND: begin
            if (outReady) begin
               out_valid_d = 1'b0;
               if (ele_sel_q == C_LAST) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  busy_d      = 1'b0;
                  ele_sel_d   = 5'd0;
                  wcnt_d      = 5'd0;
                  in_ready_d  = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  ele_sel_d = ele_sel_q + 5'd1;
                  cyc_d     = 16'd0;
                  state_d   = ST_RDADDR;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign inReady  = in_ready_q;
   assign eleSel   = ele_sel_q;
   assign eleIn    = ele_in_q;
   assign eleWe    = ele_we_q;
   assign sel      = sel_q;
   assign outData  = out_data_q;
   assign outValid = out_valid_q;
   assign busy     = busy_q;
   assign frameCnt = frame_cnt_q;

endmodule

// File: tb/tb_matrix_seq_driver.sv
// Bench for matrix_seq_driver: a default-timing instance and a slow-read / long-calc instance
// with a preset frame counter, each paired with a behavioural matrix ALU.
`timescale 1ns/1ps
module tb_matrix_seq_driver;

   typedef logic [31:0] mat_t [9];
   typedef logic [31:0] frame_t [18];
   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;
   typedef struct {
      logic [5:0]  op;
      logic [31:0] base;
      int          mode;
      int          stall_idx;
      int          stall_len;
      logic [15:0] exp_fc;
   } vec_t;

   localparam int LAT0 = 1, CALC0 = 2, LAT1 = 3, CALC1 = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opCode = 6'd0;
   logic [31:0] inData = 32'd0;
   logic        inValid = 1'b0;
   logic        outReady = 1'b0;
   logic        cur = 1'b0;

   logic [1:0]       inReady_w, eleWe_w, outValid_w, busy_w, inValid_w, outReady_w;
   logic [1:0][4:0]  eleSel_w;
   logic [1:0][31:0] eleIn_w, eleOut_w, outData_w;
   logic [1:0][5:0]  sel_w;
   logic [1:0][15:0] frameCnt_w;

   logic        inReady_s, eleWe_s, outValid_s, busy_s;
   logic [4:0]  eleSel_s;
   logic [31:0] eleIn_s, outData_s;
   logic [5:0]  sel_s;
   logic [15:0] frameCnt_s;

   int          checks = 0;
   int          failures = 0;
   wr_t         wq[$];
   logic [31:0] rq[$];
   int          res_cnt = 0;
   int          sel_cnt = 0;
   int          cyc = 0;
   int          last_rise = 0;
   bit          prev_ov = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] hold_data = 32'd0;
   logic [5:0]  exp_op = 6'd0;
   logic [15:0] exp_fc_m [2];

   always #5 clk = ~clk;

   assign inValid_w[0]  = inValid && !cur;
   assign inValid_w[1]  = inValid && cur;
   assign outReady_w[0] = outReady && !cur;
   assign outReady_w[1] = outReady && cur;

   assign inReady_s  = inReady_w[cur];
   assign eleWe_s    = eleWe_w[cur];
   assign outValid_s = outValid_w[cur];
   assign busy_s     = busy_w[cur];
   assign eleSel_s   = eleSel_w[cur];
   assign eleIn_s    = eleIn_w[cur];
   assign outData_s  = outData_w[cur];
   assign sel_s      = sel_w[cur];
   assign frameCnt_s = frameCnt_w[cur];

   matrix_seq_driver #(.CALC_CYCLES(CALC0), .RD_LAT(LAT0), .FRAME_CNT_INIT(16'h0000)) dut0 (
      .clk(clk), .reset(reset), .opCode(opCode), .inData(inData), .inValid(inValid_w[0]),
      .inReady(inReady_w[0]), .eleSel(eleSel_w[0]), .eleIn(eleIn_w[0]), .eleWe(eleWe_w[0]),
      .sel(sel_w[0]), .eleOut(eleOut_w[0]), .outData(outData_w[0]), .outValid(outValid_w[0]),
      .outReady(outReady_w[0]), .busy(busy_w[0]), .frameCnt(frameCnt_w[0]));

   matrix_seq_driver #(.CALC_CYCLES(CALC1), .RD_LAT(LAT1), .FRAME_CNT_INIT(16'hFFFF)) dut1 (
      .clk(clk), .reset(reset), .opCode(opCode), .inData(inData), .inValid(inValid_w[1]),
      .inReady(inReady_w[1]), .eleSel(eleSel_w[1]), .eleIn(eleIn_w[1]), .eleWe(eleWe_w[1]),
      .sel(sel_w[1]), .eleOut(eleOut_w[1]), .outData(outData_w[1]), .outValid(outValid_w[1]),
      .outReady(outReady_w[1]), .busy(busy_w[1]), .frameCnt(frameCnt_w[1]));

   // ALU semantics: op 1 is a 3x3 matrix product, any other op is A + op*B element-wise
   function automatic logic [31:0] alu_elem(input logic [5:0] op, input int i, input mat_t a, input mat_t b);
      logic [31:0] s;
      s = 32'd0;
      if (op == 6'd1) begin
         for (int k = 0; k < 3; k++) s = s + a[(i / 3) * 3 + k] * b[k * 3 + (i % 3)];
      end else begin
         s = a[i] + b[i] * {26'd0, op};
      end
      return s;
   endfunction

   function automatic logic [31:0] pick(input mat_t a, input mat_t b, input mat_t c, input int idx);
      if (idx < 9) return a[idx];
      if (idx < 18) return b[idx - 9];
      if (idx < 27) return c[idx - 18];
      return 32'h0BAD0BAD;
   endfunction

   // Mock ALU: read data appears RD_LAT-1 register stages after the address
   for (genvar gi = 0; gi < 2; gi++) begin : g_alu
      mat_t       ma, mb, mc;
      logic [4:0] p0, p1, ra;
      always @(posedge clk) begin
         p0 <= eleSel_w[gi];
         p1 <= p0;
         if (eleWe_w[gi]) begin
            if (int'(eleSel_w[gi]) < 9) ma[int'(eleSel_w[gi])] <= eleIn_w[gi];
            else if (int'(eleSel_w[gi]) < 18) mb[int'(eleSel_w[gi]) - 9] <= eleIn_w[gi];
         end
         if (sel_w[gi] != 6'd0) begin
            for (int i = 0; i < 9; i++) mc[i] <= alu_elem(sel_w[gi], i, ma, mb);
         end
      end
      assign ra = (gi == 0) ? eleSel_w[gi] : p1;
      assign eleOut_w[gi] = pick(ma, mb, mc, int'(ra));
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: write strobes, op select, result stream, hold/spacing rules
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            if (eleWe_s) begin
               if (wq.size() == 0) begin
                  chk(1'b0, "unexpected_write", 32'(eleSel_s), 32'd0);
               end else begin
                  e = wq.pop_front();
                  chk(eleSel_s == e.idx, "write_index", 32'(eleSel_s), 32'(e.idx));
                  chk(eleIn_s == e.data, "write_data", eleIn_s, e.data);
               end
            end
            if (sel_s != 6'd0) begin
               sel_cnt++;
               chk(sel_s == exp_op, "sel_value", 32'(sel_s), 32'(exp_op));
               chk(!eleWe_s, "sel_during_write", 32'(eleWe_s), 32'd0);
            end
            if (eleWe_s || sel_s != 6'd0 || outValid_s)
               chk(busy_s, "busy_active", 32'(busy_s), 32'd1);
            if (outValid_s) begin
               chk(eleSel_s == 5'(18 + res_cnt), "result_elesel", 32'(eleSel_s), 32'(18 + res_cnt));
               if (!prev_ov && res_cnt > 0)
                  chk(cyc - last_rise >= (cur ? LAT1 : LAT0) + 1, "result_spacing", 32'(cyc - last_rise), 32'((cur ? LAT1 : LAT0) + 1));
               if (!prev_ov) last_rise = cyc;
               if (prev_hold) chk(outData_s == hold_data, "result_hold", outData_s, hold_data);
               if (outReady) begin
                  if (rq.size() == 0) chk(1'b0, "unexpected_result", outData_s, 32'd0);
                  else begin
                     hold_data = rq.pop_front();
                     chk(outData_s == hold_data, "result_data", outData_s, hold_data);
                  end
                  res_cnt++;
                  prev_hold = 1'b0;
               end else begin
                  prev_hold = 1'b1;
                  hold_data = outData_s;
               end
            end else begin
               prev_hold = 1'b0;
            end
            prev_ov = outValid_s;
         end
      end
   end

   // mode: 0 dense, 1 inValid every other cycle, 2 random gaps.
   // junk: inValid=1 with 0xDEAD after the load phase. reset_at: pulse reset during that result.
   task automatic run_frame(input logic [5:0] op, input frame_t w, input int mode, input int stall_idx,
                            input int stall_len, input bit rnd_ready, input bit junk, input int reset_at);
      int   idx, tmo, ph, stall_left;
      mat_t a, b;
      idx = 0; tmo = 0; ph = 0; stall_left = stall_len;
      res_cnt = 0; sel_cnt = 0; exp_op = op; prev_hold = 1'b0; prev_ov = 1'b0;
      while (idx < 18 && tmo < 400) begin
         case (mode)
            0: inValid = 1'b1;
            1: inValid = (ph % 2 == 0);
            default: inValid = ($urandom_range(0, 9) < 7);
         endcase
         ph++;
         inData   = inValid ? w[idx] : $urandom;
         opCode   = (idx == 0) ? op : 6'($urandom);
         outReady = 1'($urandom);
         if (inValid && inReady_s) begin
            wq.push_back('{5'(idx), w[idx]});
            idx++;
         end
         @(posedge clk); #1;
         tmo++;
      end
      chk(idx == 18, "load_timeout", 32'(idx), 32'd18);
      chk(!inReady_s, "inready_drop", 32'(inReady_s), 32'd0);
      inValid = junk;
      inData  = 32'hDEAD;
      for (int j = 0; j < 9; j++) begin
         a[j] = w[j];
         b[j] = w[9 + j];
      end
      for (int i = 0; i < 9; i++) rq.push_back(alu_elem(op, i, a, b));
      tmo = 0;
      while (res_cnt < 9 && tmo < 600) begin
         if (junk) chk(!inReady_s, "junk_inready", 32'(inReady_s), 32'd0);
         if (reset_at >= 0 && res_cnt == reset_at && outValid_s) begin
            #1 reset = 1'b1;
            #1;
            chk(!outValid_s, "rst_outvalid", 32'(outValid_s), 32'd0);
            chk(!eleWe_s, "rst_elewe", 32'(eleWe_s), 32'd0);
            chk(!busy_s, "rst_busy", 32'(busy_s), 32'd0);
            chk(!inReady_s, "rst_inready", 32'(inReady_s), 32'd0);
            chk(eleSel_s == 5'd0, "rst_elesel", 32'(eleSel_s), 32'd0);
            chk(outData_s == 32'd0, "rst_outdata", outData_s, 32'd0);
            chk(frameCnt_s == (cur ? 16'hFFFF : 16'h0000), "rst_framecnt", 32'(frameCnt_s), 32'(cur ? 16'hFFFF : 16'h0000));
            inValid = 1'b0;
            outReady = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            wq.delete();
            rq.delete();
            res_cnt = 0; prev_ov = 1'b0; prev_hold = 1'b0;
            exp_fc_m[0] = 16'h0000;
            exp_fc_m[1] = 16'hFFFF;
            @(posedge clk); #1;
            return;
         end
         if (outValid_s && res_cnt == stall_idx && stall_left > 0) begin
            outReady = 1'b0;
            stall_left--;
         end else begin
            outReady = rnd_ready ? 1'($urandom) : 1'b1;
         end
         @(posedge clk); #1;
         tmo++;
      end
      inValid  = 1'b0;
      outReady = 1'b0;
      chk(res_cnt == 9, "result_timeout", 32'(res_cnt), 32'd9);
      exp_fc_m[cur] = exp_fc_m[cur] + 16'd1;
      chk(frameCnt_s == exp_fc_m[cur], "frame_cnt", 32'(frameCnt_s), 32'(exp_fc_m[cur]));
      chk(!busy_s, "busy_end", 32'(busy_s), 32'd0);
      chk(inReady_s, "inready_end", 32'(inReady_s), 32'd1);
      chk(eleSel_s == 5'd0, "elesel_end", 32'(eleSel_s), 32'd0);
      chk(sel_cnt == (cur ? CALC1 : CALC0), "sel_cycles", 32'(sel_cnt), 32'(cur ? CALC1 : CALC0));
      chk(wq.size() == 0, "writes_missing", 32'(wq.size()), 32'd0);
      chk(rq.size() == 0, "results_missing", 32'(rq.size()), 32'd0);
   endtask

   initial begin
      vec_t   vt [4];
      frame_t w;
      vt[0] = '{6'd1,  32'd1,        0, -1, 0, 16'd1};
      vt[1] = '{6'd3,  32'd100,      1, -1, 0, 16'd2};
      vt[2] = '{6'd2,  32'h1000,     0,  4, 5, 16'd3};
      vt[3] = '{6'd63, 32'hFFFF_FFF0, 1, 8, 2, 16'd4};
      exp_fc_m[0] = 16'h0000;
      exp_fc_m[1] = 16'hFFFF;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk(!inReady_s, "reset_inready", 32'(inReady_s), 32'd0);
      chk(eleSel_s == 5'd0 && eleIn_s == 32'd0, "reset_ele", 32'(eleSel_s) ^ eleIn_s, 32'd0);
      chk(!eleWe_s && sel_s == 6'd0, "reset_we_sel", 32'(sel_s), 32'd0);
      chk(!outValid_s && outData_s == 32'd0, "reset_out", outData_s, 32'd0);
      chk(!busy_s && frameCnt_s == 16'd0, "reset_busy_cnt", 32'(frameCnt_s), 32'd0);
      chk(frameCnt_w[1] == 16'hFFFF, "reset_preset_cnt", 32'(frameCnt_w[1]), 32'hFFFF);
      reset = 1'b0;
      @(posedge clk); #1;
      chk(inReady_s, "inready_after_reset", 32'(inReady_s), 32'd1);

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 18; j++) w[j] = vt[i].base + 32'(j);
         run_frame(vt[i].op, w, vt[i].mode, vt[i].stall_idx, vt[i].stall_len, 1'b0, 1'b0, -1);
         chk(frameCnt_s == vt[i].exp_fc, "vec_frame_cnt", 32'(frameCnt_s), 32'(vt[i].exp_fc));
      end

      for (int j = 0; j < 18; j++) w[j] = 32'(j * 7 + 3);
      run_frame(6'd5, w, 0, -1, 0, 1'b0, 1'b1, -1);

      for (int f = 0; f < 10; f++) begin
         for (int j = 0; j < 18; j++) w[j] = $urandom;
         run_frame(6'($urandom_range(1, 63)), w, 2, $urandom_range(0, 8), $urandom_range(0, 4), 1'b1, 1'b0, -1);
      end

      for (int j = 0; j < 18; j++) w[j] = $urandom;
      run_frame(6'd1, w, 0, -1, 0, 1'b0, 1'b0, 3);
      for (int j = 0; j < 18; j++) w[j] = $urandom;
      run_frame(6'd7, w, 0, -1, 0, 1'b0, 1'b0, -1);
      chk(frameCnt_s == 16'd1, "frame_cnt_after_reset", 32'(frameCnt_s), 32'd1);

      cur = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 18; j++) w[j] = $urandom;
      run_frame(6'd1, w, 0, -1, 0, 1'b0, 1'b0, -1);
      chk(frameCnt_s == 16'h0000, "frame_cnt_wrap", 32'(frameCnt_s), 32'd0);
      for (int j = 0; j < 18; j++) w[j] = $urandom;
      run_frame(6'($urandom_range(1, 63)), w, 2, 2, 3, 1'b1, 1'b1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
